// File: rtl/axis_func_sched_pkg.sv
// Shared state type and sizing helpers for the per-function AXIS round-robin scheduler.
package axis_func_sched_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, SWITCH} sched_state_t;

  function automatic int func_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction

  function automatic int next_idx(input int i, input int n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: lowest set request at or after start, wrapping past N-1.
module rr_prio_enc
  import axis_func_sched_pkg::*;
#(
  parameter  int N = 256,
  localparam int W = func_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] grant,
  output logic         any
);

  logic [2*N-1:0] masked;
  logic [W:0]     first;

  // Doubling the request vector turns the wrap-around search into a plain find-first.
  always_comb begin
    masked = {req, req} & ({(2*N){1'b1}} << start);
    first  = '0;
    for (int i = 2*N - 1; i >= 0; i--) begin
      if (masked[i]) first = (W+1)'(i);
    end
  end

  assign any   = |req;
  assign grant = (first >= (W+1)'(N)) ? W'(first - (W+1)'(N)) : first[W-1:0];

endmodule

// File: rtl/axis_func_rr_sched.sv
// Dequeue-side round-robin scheduler tracking per-function FIFO occupancy.
// Optional statistics outputs enabled by defining AXIS_FUNC_SCHED_STATS_EN.
module axis_func_rr_sched
  import axis_func_sched_pkg::*;
#(
  parameter  int NUM_FUNCS = 256,
  parameter  int DEPTH     = 4096,
  parameter  int QUANTUM   = 16,
  localparam int FUNC_W    = func_w(NUM_FUNCS),
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FUNC_W-1:0] enq_func,
  input  logic              enq_fire,
  input  logic              deq_fire,
  output logic [FUNC_W-1:0] curr_func_out,
  output logic              curr_func_out_valid,
  output logic              sched_err
`ifdef AXIS_FUNC_SCHED_STATS_EN
  ,
  output logic [$clog2(NUM_FUNCS*DEPTH+1)-1:0] total_pending,
  output logic [31:0]                          grant_count
`endif
);

  localparam int BEAT_W = cnt_w(QUANTUM);

  logic [CNT_W-1:0]     cnt [NUM_FUNCS];
  logic [NUM_FUNCS-1:0] nonempty;
  sched_state_t         state;
  logic [FUNC_W-1:0]    last_ptr;
  logic [FUNC_W-1:0]    start_idx;
  logic [FUNC_W-1:0]    next_func;
  logic [BEAT_W-1:0]    beat_cnt;
  logic                 any_req;
  logic                 enq_in_range;
  logic                 enq_full;
  logic                 enq_ok;
  logic                 deq_ok;
  logic                 enq_to_curr;
  logic                 last_beat;

  always_comb begin
    for (int f = 0; f < NUM_FUNCS; f++) nonempty[f] = (cnt[f] != '0);
  end

  assign enq_in_range = (int'(enq_func) < NUM_FUNCS);
  assign enq_full     = enq_in_range && (cnt[enq_func] == CNT_W'(DEPTH));
  assign enq_ok       = enq_fire && enq_in_range && !enq_full;
  assign deq_ok       = deq_fire && curr_func_out_valid && (cnt[curr_func_out] != '0);
  assign enq_to_curr  = enq_ok && (enq_func == curr_func_out);
  assign last_beat    = (beat_cnt == BEAT_W'(QUANTUM - 1)) ||
                        ((cnt[curr_func_out] == CNT_W'(1)) && !enq_to_curr);
  assign start_idx    = FUNC_W'(next_idx(int'(last_ptr), NUM_FUNCS));

  rr_prio_enc #(.N(NUM_FUNCS)) u_prio (
    .req   (nonempty),
    .start (start_idx),
    .grant (next_func),
    .any   (any_req)
  );

  // Same-cycle enqueue and dequeue on one function cancel; full enqueues are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FUNCS; f++) cnt[f] <= '0;
      sched_err <= 1'b0;
    end else begin
      for (int f = 0; f < NUM_FUNCS; f++) begin
        if (enq_ok && (enq_func == FUNC_W'(f)) && !(deq_ok && (curr_func_out == FUNC_W'(f))))
          cnt[f] <= cnt[f] + CNT_W'(1);
        else if (deq_ok && (curr_func_out == FUNC_W'(f)) && !(enq_ok && (enq_func == FUNC_W'(f))))
          cnt[f] <= cnt[f] - CNT_W'(1);
      end
      if ((enq_fire && enq_full) || (deq_fire && !curr_func_out_valid)) sched_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      curr_func_out       <= '0;
      curr_func_out_valid <= 1'b0;
      last_ptr            <= FUNC_W'(NUM_FUNCS - 1);
      beat_cnt            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            curr_func_out       <= next_func;
            curr_func_out_valid <= 1'b1;
            beat_cnt            <= '0;
            state               <= GRANT;
          end
        end
        GRANT: begin
          if (deq_fire) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (last_beat) begin
              curr_func_out_valid <= 1'b0;
              last_ptr            <= curr_func_out;
              state               <= SWITCH;
            end
          end
        end
        SWITCH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_FUNC_SCHED_STATS_EN
  localparam int PEND_W = $clog2(NUM_FUNCS*DEPTH+1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_pending <= '0;
      grant_count   <= '0;
    end else begin
      if (enq_ok && !deq_ok)      total_pending <= total_pending + PEND_W'(1);
      else if (deq_ok && !enq_ok) total_pending <= total_pending - PEND_W'(1);
      if ((state == IDLE) && any_req) grant_count <= grant_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_func_rr_sched.sv
// Directed bench for axis_func_rr_sched; a monitor pops the expected grant scoreboard.
module tb_axis_func_rr_sched;

  localparam int NUM_FUNCS = 256;
  localparam int DEPTH     = 4096;
  localparam int QUANTUM   = 16;

  typedef struct {
    logic [7:0] func;
    int         beats;
    int         gap;
  } grant_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] enq_func = '0;
  logic       enq_fire = 1'b0;
  logic       deq_fire = 1'b0;
  logic [7:0] curr_func_out;
  logic       curr_func_out_valid;
  logic       sched_err;
`ifdef AXIS_FUNC_SCHED_STATS_EN
  logic [20:0] total_pending;
  logic [31:0] grant_count;
`endif

  int     checks = 0;
  int     failures = 0;
  grant_t exp_q[$];

  always #5 clk = ~clk;

  axis_func_rr_sched #(
    .NUM_FUNCS (NUM_FUNCS),
    .DEPTH     (DEPTH),
    .QUANTUM   (QUANTUM)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enq_func            (enq_func),
    .enq_fire            (enq_fire),
    .deq_fire            (deq_fire),
    .curr_func_out       (curr_func_out),
    .curr_func_out_valid (curr_func_out_valid),
    .sched_err           (sched_err)
`ifdef AXIS_FUNC_SCHED_STATS_EN
    ,
    .total_pending       (total_pending),
    .grant_count         (grant_count)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and are held through the next one.
  task automatic applyStimulus(input logic [7:0] f, input logic e, input logic d);
    enq_func = f;
    enq_fire = e;
    deq_fire = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) applyStimulus(8'd0, 1'b0, curr_func_out_valid);
  endtask

  task automatic expectGrant(input logic [7:0] f, input int beats, input int gap);
    grant_t g;
    g.func  = f;
    g.beats = beats;
    g.gap   = gap;
    exp_q.push_back(g);
  endtask

  logic prev_valid = 1'b0;
  int   gap_cnt = 0;
  int   beat_obs = 0;

  // Grant monitor: checks function and gap at each rise, beat total at each fall.
  always @(negedge clk) begin
    if (curr_func_out_valid && !prev_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("[TB] FAIL unexpected_grant: observed func=%0d expected no grant", curr_func_out);
      end
      if (exp_q.size() != 0) begin
        checkOutput("grant_func", 32'(curr_func_out), 32'(exp_q[0].func));
        if (exp_q[0].gap != 0) checkOutput("grant_gap", gap_cnt, exp_q[0].gap);
      end
      beat_obs = 0;
    end else if (!curr_func_out_valid && prev_valid) begin
      if (exp_q.size() != 0) begin
        checkOutput("grant_beats", beat_obs, exp_q[0].beats);
        void'(exp_q.pop_front());
      end
      gap_cnt = 0;
    end
    if (curr_func_out_valid && deq_fire) beat_obs++;
    if (!curr_func_out_valid) gap_cnt++;
    prev_valid = curr_func_out_valid;
  end

  initial begin
    repeat (2) applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("rst_valid", 32'(curr_func_out_valid), 0);
    checkOutput("rst_func", 32'(curr_func_out), 0);
    checkOutput("rst_err", 32'(sched_err), 0);
`ifdef AXIS_FUNC_SCHED_STATS_EN
    checkOutput("rst_total_pending", 32'(total_pending), 0);
    checkOutput("rst_grant_count", grant_count, 0);
`endif
    rst_n = 1'b1;
    applyStimulus(8'd0, 1'b0, 1'b0);

    $display("[TB] step 1: three beats on func 5");
    expectGrant(8'd5, 3, 0);
    applyStimulus(8'd5, 1'b1, 1'b0);
    checkOutput("t1_valid_after_first_enq", 32'(curr_func_out_valid), 0);
    applyStimulus(8'd5, 1'b1, 1'b0);
    checkOutput("t1_valid_rise", 32'(curr_func_out_valid), 1);
    checkOutput("t1_func", 32'(curr_func_out), 5);
    applyStimulus(8'd5, 1'b1, 1'b0);
    drain(3);
    checkOutput("t1_valid_switch", 32'(curr_func_out_valid), 0);
    checkOutput("t1_func_hold", 32'(curr_func_out), 5);
    drain(3);
    checkOutput("t1_idle_empty", 32'(curr_func_out_valid), 0);

    $display("[TB] step 2: 40 beats on func 7 split by quantum");
    expectGrant(8'd7, 16, 0);
    expectGrant(8'd7, 16, 2);
    expectGrant(8'd7, 8, 2);
    repeat (40) applyStimulus(8'd7, 1'b1, 1'b0);
    drain(50);
    checkOutput("t2_idle_after", 32'(curr_func_out_valid), 0);

    $display("[TB] step 3: round robin over 2, 255, 0 from last_ptr 1");
    expectGrant(8'd1, 1, 0);
    applyStimulus(8'd1, 1'b1, 1'b0);
    drain(6);
    expectGrant(8'd2, 4, 0);
    expectGrant(8'd255, 4, 2);
    expectGrant(8'd0, 4, 2);
    repeat (4) applyStimulus(8'd2, 1'b1, 1'b0);
    repeat (4) applyStimulus(8'd255, 1'b1, 1'b0);
    repeat (4) applyStimulus(8'd0, 1'b1, 1'b0);
    drain(24);
    checkOutput("t3_no_fourth_grant", 32'(curr_func_out_valid), 0);
    expectGrant(8'd2, 2, 0);
    repeat (2) applyStimulus(8'd2, 1'b1, 1'b0);
    drain(8);

    $display("[TB] step 4: simultaneous enq and deq on the last beat");
    expectGrant(8'd3, 2, 0);
    applyStimulus(8'd3, 1'b1, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("t4_valid", 32'(curr_func_out_valid), 1);
    checkOutput("t4_func", 32'(curr_func_out), 3);
    applyStimulus(8'd3, 1'b1, 1'b1);
    checkOutput("t4_grant_continues", 32'(curr_func_out_valid), 1);
    applyStimulus(8'd0, 1'b0, 1'b1);
    checkOutput("t4_grant_ends", 32'(curr_func_out_valid), 0);
    drain(3);
    checkOutput("t4_empty", 32'(curr_func_out_valid), 0);
    checkOutput("t4_err_clear", 32'(sched_err), 0);

    $display("[TB] step 5: overflow func 9");
    for (int i = 0; i < DEPTH / QUANTUM; i++) expectGrant(8'd9, QUANTUM, (i == 0) ? 0 : 2);
    repeat (DEPTH) applyStimulus(8'd9, 1'b1, 1'b0);
    checkOutput("t5_err_at_depth", 32'(sched_err), 0);
    applyStimulus(8'd9, 1'b1, 1'b0);
    checkOutput("t5_err_on_overflow", 32'(sched_err), 1);
    drain((DEPTH / QUANTUM) * (QUANTUM + 2) + 8);
    checkOutput("t5_err_sticky", 32'(sched_err), 1);
    checkOutput("t5_idle_after", 32'(curr_func_out_valid), 0);

    $display("[TB] step 6: reset during grant to func 4");
    expectGrant(8'd4, 0, 0);
    repeat (10) applyStimulus(8'd4, 1'b1, 1'b0);
    checkOutput("t6_valid_before_rst", 32'(curr_func_out_valid), 1);
    checkOutput("t6_func_before_rst", 32'(curr_func_out), 4);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(curr_func_out_valid), 0);
    checkOutput("t6_rst_func", 32'(curr_func_out), 0);
    checkOutput("t6_rst_err", 32'(sched_err), 0);
`ifdef AXIS_FUNC_SCHED_STATS_EN
    checkOutput("t6_rst_total_pending", 32'(total_pending), 0);
    checkOutput("t6_rst_grant_count", grant_count, 0);
`endif
    repeat (2) applyStimulus(8'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drain(3);
    checkOutput("t6_counts_cleared", 32'(curr_func_out_valid), 0);
    expectGrant(8'd0, 1, 0);
    applyStimulus(8'd0, 1'b1, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("t6_first_grant_valid", 32'(curr_func_out_valid), 1);
    checkOutput("t6_first_grant_func", 32'(curr_func_out), 0);
`ifdef AXIS_FUNC_SCHED_STATS_EN
    checkOutput("t6_total_pending_one", 32'(total_pending), 1);
    checkOutput("t6_grant_count_one", grant_count, 1);
`endif
    drain(6);
    checkOutput("t6_idle_after", 32'(curr_func_out_valid), 0);
`ifdef AXIS_FUNC_SCHED_STATS_EN
    checkOutput("t6_total_pending_zero", 32'(total_pending), 0);
    checkOutput("t6_grant_count_after", grant_count, 1);
`endif

    $display("[TB] step 7: dequeue with no grant");
    checkOutput("t7_err_clear", 32'(sched_err), 0);
    applyStimulus(8'd0, 1'b0, 1'b1);
    checkOutput("t7_err_deq_idle", 32'(sched_err), 1);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("t7_err_sticky", 32'(sched_err), 1);
    checkOutput("t7_valid_still_low", 32'(curr_func_out_valid), 0);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
